mesh_router_node: RTL and testbench

//  Parametrised N-port buffered router node for the interconnect network; next generation of the

---
 rtl/mesh_router_node.sv | 135 +++++++++++++
 tb/tb_mesh_router_node.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mesh_router_node.sv
// N-port buffered mesh router node: per-input FIFOs, header-based routing,
// per-output round-robin arbitration and registered valid/ready outputs.
module mesh_router_node #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_PORTS      = 3,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned DROP_CNT_WIDTH = 8
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_in_data,
  input  logic [NUM_PORTS-1:0]            i_in_valid,
  output logic [NUM_PORTS-1:0]            o_in_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] o_out_data,
  output logic [NUM_PORTS-1:0]            o_out_valid,
  input  logic [NUM_PORTS-1:0]            i_out_ready,
  output logic [DROP_CNT_WIDTH-1:0]       o_drop_count
);

  localparam int unsigned PORT_BITS = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned ADDR_BITS = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_BITS  = ADDR_BITS + 1;

  logic [DATA_WIDTH-1:0]     r_mem [NUM_PORTS][FIFO_DEPTH];
  logic [PTR_BITS-1:0]       r_wr_ptr [NUM_PORTS];
  logic [PTR_BITS-1:0]       r_rd_ptr [NUM_PORTS];
  logic [DATA_WIDTH-1:0]     r_out_data [NUM_PORTS];
  logic [NUM_PORTS-1:0]      r_out_valid;
  logic [PORT_BITS-1:0]      r_rr_ptr [NUM_PORTS];
  logic [DROP_CNT_WIDTH-1:0] r_drop_count;

  logic [DATA_WIDTH-1:0]     w_head [NUM_PORTS];
  logic [PORT_BITS-1:0]      w_dest [NUM_PORTS];
  logic [NUM_PORTS-1:0]      w_empty;
  logic [NUM_PORTS-1:0]      w_full;
  logic [NUM_PORTS-1:0]      w_dest_ok;
  logic [NUM_PORTS-1:0]      w_drop;
  logic [NUM_PORTS-1:0]      w_push;
  logic [NUM_PORTS-1:0]      w_pop;
  logic [NUM_PORTS-1:0]      w_load;
  logic [NUM_PORTS-1:0]      w_grant_vld;
  logic [PORT_BITS-1:0]      w_grant [NUM_PORTS];
  logic [DROP_CNT_WIDTH-1:0] w_drop_next;

  // Readiness comes only from registered fullness, forced low during reset.
  assign o_in_ready   = ~w_full & {NUM_PORTS{~i_reset}};
  assign o_out_valid  = r_out_valid;
  assign o_drop_count = r_drop_count;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_out_flat
    assign o_out_data[g*DATA_WIDTH +: DATA_WIDTH] = r_out_data[g];
  end

  // FIFO status and head decode.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      w_head[p]    = r_mem[p][r_rd_ptr[p][ADDR_BITS-1:0]];
      w_dest[p]    = w_head[p][DATA_WIDTH-1 -: PORT_BITS];
      w_empty[p]   = (r_wr_ptr[p] == r_rd_ptr[p]);
      w_full[p]    = ((r_wr_ptr[p] - r_rd_ptr[p]) == PTR_BITS'(FIFO_DEPTH));
      w_dest_ok[p] = ({1'b0, w_dest[p]} < (PORT_BITS+1)'(NUM_PORTS));
      w_drop[p]    = !w_empty[p] && !w_dest_ok[p];
      w_push[p]    = i_in_valid[p] && o_in_ready[p];
    end
  end

  // Per-output round-robin arbitration; invalid heads are popped without arbitration.
  always_comb begin
    logic [PORT_BITS-1:0] w_idx;
    w_idx       = '0;
    w_load      = '0;
    w_grant_vld = '0;
    w_pop       = w_drop;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      w_grant[o] = '0;
      w_load[o]  = !r_out_valid[o] || i_out_ready[o];
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        w_idx = PORT_BITS'((32'(r_rr_ptr[o]) + k) % NUM_PORTS);
        if (w_load[o] && !w_grant_vld[o] && !w_empty[w_idx] && w_dest_ok[w_idx] &&
            (w_dest[w_idx] == PORT_BITS'(o))) begin
          w_grant_vld[o] = 1'b1;
          w_grant[o]     = w_idx;
          w_pop[w_idx]   = 1'b1;
        end
      end
    end
  end

  // Saturating count of discarded words, one per dropping input.
  always_comb begin
    w_drop_next = r_drop_count;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (w_drop[p] && (w_drop_next != '1)) begin
        w_drop_next = w_drop_next + DROP_CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (w_push[p]) begin
        r_mem[p][r_wr_ptr[p][ADDR_BITS-1:0]] <= i_in_data[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        r_wr_ptr[p]   <= '0;
        r_rd_ptr[p]   <= '0;
        r_out_data[p] <= '0;
        r_rr_ptr[p]   <= '0;
      end
      r_out_valid  <= '0;
      r_drop_count <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (w_push[p]) r_wr_ptr[p] <= r_wr_ptr[p] + PTR_BITS'(1);
        if (w_pop[p])  r_rd_ptr[p] <= r_rd_ptr[p] + PTR_BITS'(1);
      end
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        if (w_load[o]) begin
          r_out_valid[o] <= w_grant_vld[o];
          if (w_grant_vld[o]) begin
            r_out_data[o] <= w_head[w_grant[o]];
            r_rr_ptr[o]   <= PORT_BITS'((32'(w_grant[o]) + 32'd1) % NUM_PORTS);
          end
        end
      end
      r_drop_count <= w_drop_next;
    end
  end

endmodule

// File: tb/tb_mesh_router_node.sv
// Directed self-checking bench for mesh_router_node (3 ports, 32-bit words, depth 4).
module tb_mesh_router_node;

  logic        clk;
  logic        reset;
  logic [95:0] in_data;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [95:0] out_data;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [3:0]  drop_count;

  int n_checks = 0;
  int n_errors = 0;

  mesh_router_node #(
    .DATA_WIDTH(32), .NUM_PORTS(3), .FIFO_DEPTH(4), .DROP_CNT_WIDTH(4)
  ) u_dut (
    .i_clk(clk), .i_reset(reset),
    .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] out_word(input int o);
    return out_data[o*32 +: 32];
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] seen;
    int acc;
    int pushes;

    reset     = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    out_ready = 3'b111;
    repeat (3) step();
    check_eq("rst_in_ready", 64'(in_ready), 64'h0);
    check_eq("rst_out_valid", 64'(out_valid), 64'h0);
    check_eq("rst_out_data", 64'(out_data[63:0]), 64'h0);
    check_eq("rst_drop", 64'(drop_count), 64'h0);
    reset = 1'b0;
    #1;
    check_eq("post_rst_in_ready", 64'(in_ready), 64'h7);

    // Single word, port1 -> output 2, two-edge latency
    step();
    in_data[63:32] = 32'h8000_0049;
    in_valid       = 3'b010;
    step();
    in_valid = '0;
    check_eq("single_edge1", 64'(out_valid), 64'h0);
    step();
    check_eq("single_valid", 64'(out_valid), 64'h4);
    check_eq("single_data", 64'(out_word(2)), 64'h8000_0049);
    step();
    check_eq("single_gone", 64'(out_valid), 64'h0);

    // Three-way contention on output 0
    in_data  = {32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
    in_valid = 3'b111;
    step();
    in_valid = '0;
    step();
    check_eq("cont_v0", 64'(out_valid), 64'h1);
    check_eq("cont_d0", 64'(out_word(0)), 64'h0);
    step();
    check_eq("cont_v1", 64'(out_valid), 64'h1);
    check_eq("cont_d1", 64'(out_word(0)), 64'h1);
    step();
    check_eq("cont_v2", 64'(out_valid), 64'h1);
    check_eq("cont_d2", 64'(out_word(0)), 64'h2);
    step();
    check_eq("cont_idle", 64'(out_valid), 64'h0);

    // Pointer back at 0: ports 0 and 2 compete, port 0 wins first
    in_data  = {32'h0000_0022, 32'h0000_0000, 32'h0000_0020};
    in_valid = 3'b101;
    step();
    in_valid = '0;
    step();
    check_eq("rr_first", 64'(out_word(0)), 64'h20);
    step();
    check_eq("rr_second", 64'(out_word(0)), 64'h22);
    check_eq("rr_second_v", 64'(out_valid), 64'h1);
    step();

    // Backpressure on output 1: 1 word in output reg + 4 in FIFO
    out_ready = 3'b101;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      if (in_ready[0] && acc < 6) begin
        in_data[31:0] = 32'h4000_0000 + 32'(acc);
        in_valid      = 3'b001;
        acc++;
      end else begin
        in_valid = '0;
      end
      step();
    end
    in_valid = '0;
    check_eq("bp_accepted", 64'(acc), 64'd5);
    check_eq("bp_in_ready", 64'(in_ready), 64'h6);
    check_eq("bp_hold_v", 64'(out_valid), 64'h2);
    check_eq("bp_hold_d", 64'(out_word(1)), 64'h4000_0000);
    out_ready = 3'b111;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("bp_drain_v%0d", i), 64'(out_valid[1]), 64'h1);
      check_eq($sformatf("bp_drain_d%0d", i), 64'(out_word(1)), 64'h4000_0000 + 64'(i));
      step();
    end
    check_eq("bp_drained", 64'(out_valid), 64'h0);
    check_eq("bp_ready_back", 64'(in_ready), 64'h7);

    // Invalid destination on port 2 is dropped
    in_data[95:64] = 32'hC400_0000;
    in_valid       = 3'b100;
    step();
    in_valid = '0;
    check_eq("inv_drop_pre", 64'(drop_count), 64'h0);
    step();
    check_eq("inv_drop", 64'(drop_count), 64'h1);
    check_eq("inv_no_out", 64'(out_valid), 64'h0);
    in_data[95:64] = 32'h4000_0077;
    in_valid       = 3'b100;
    step();
    in_valid = '0;
    step();
    check_eq("inv_next_v", 64'(out_valid), 64'h2);
    check_eq("inv_next_d", 64'(out_word(1)), 64'h4000_0077);
    step();

    // Reset while words are in flight
    out_ready = 3'b000;
    in_data   = {32'h4000_0BB2, 32'h0000_0AA1, 32'h0000_0AA0};
    in_valid  = 3'b111;
    repeat (2) step();
    in_valid = '0;
    repeat (2) step();
    check_eq("mid_pre_v0", 64'(out_valid[0]), 64'h1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_ready", 64'(in_ready), 64'h0);
    step();
    reset = 1'b0;
    #1;
    check_eq("mid_out_valid", 64'(out_valid), 64'h0);
    check_eq("mid_drop", 64'(drop_count), 64'h0);
    check_eq("mid_in_ready", 64'(in_ready), 64'h7);
    out_ready = 3'b111;
    seen = '0;
    for (int c = 0; c < 8; c++) begin
      step();
      seen |= out_valid;
    end
    check_eq("mid_no_stale", 64'(seen), 64'h0);

    // Drop counter saturation
    pushes = 0;
    seen   = '0;
    for (int c = 0; c < 40; c++) begin
      if (in_ready[0] && pushes < 20) begin
        in_data[31:0] = 32'hC000_0000;
        in_valid      = 3'b001;
        pushes++;
      end else begin
        in_valid = '0;
      end
      step();
      seen |= out_valid;
    end
    in_valid = '0;
    check_eq("sat_drop", 64'(drop_count), 64'hF);
    check_eq("sat_no_out", 64'(seen), 64'h0);
    repeat (5) step();
    check_eq("sat_hold", 64'(drop_count), 64'hF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
